// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one uart_tx serializer among NUM_REQ byte-stream requesters.
//   Round-robin arbitration is decided only in IDLE. A grant is then locked
//   for a whole burst. A burst ends on req_last, after MAX_BURST bytes, or
//   when the granted requester runs dry after at least one byte. When TAG_EN
//   is set, each burst starts with the tag byte TAG_BASE | grant_id.
//
// Ports
//   clk, rst_n    single clock, synchronous active-low reset
//   req_valid     per-requester byte available
//   req_data      per-requester byte, requester i at [8i+7:8i]
//   req_last      per-requester end-of-burst marker
//   req_ready     one-hot accept strobe (combinational, only in LOAD)
//   tx_data       byte presented to uart_tx (registered)
//   tx_start      one-cycle start pulse to uart_tx (registered)
//   tx_busy       uart_tx busy
//   grant_valid   a burst is in progress
//   grant_id      current or most recently granted requester
//   busy_err      sticky: uart_tx did not raise busy within 3 cycles of a start
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ   = 4,
   parameter bit          TAG_EN    = 1'b1,
   parameter logic [7:0]  TAG_BASE  = 8'hA0,
   parameter int unsigned MAX_BURST = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [8*NUM_REQ-1:0]   req_data,
   input  logic [NUM_REQ-1:0]     req_last,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [7:0]             tx_data,
   output logic                   tx_start,
   input  logic                   tx_busy,
   output logic                   grant_valid,
   output logic [2:0]             grant_id,
   output logic                   busy_err
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_TAG     = 3'd1,
      S_LOAD    = 3'd2,
      S_WAIT_HI = 3'd3,
      S_WAIT_LO = 3'd4
   } state_t;

   localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

   state_t      state_q, state_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        tx_start_q, tx_start_d;
   logic        grant_valid_q, grant_valid_d;
   logic [2:0]  grant_id_q, grant_id_d;
   logic        busy_err_q, busy_err_d;
   logic [2:0]  rr_ptr_q, rr_ptr_d;
   logic [7:0]  beat_cnt_q, beat_cnt_d;
   logic        last_flag_q, last_flag_d;
   logic        is_tag_q, is_tag_d;
   logic [1:0]  hi_cnt_q, hi_cnt_d;

   // Signals of the currently granted requester.
   logic        sel_valid, sel_last, xfer;
   logic [7:0]  sel_data;

   assign sel_valid = 1'(req_valid >> grant_id_q);
   assign sel_last  = 1'(req_last >> grant_id_q);
   assign sel_data  = 8'(req_data >> {grant_id_q, 3'b000});
   assign xfer      = (state_q == S_LOAD) && sel_valid && !tx_busy;
   assign req_ready = xfer ? (ONE_HOT0 << grant_id_q) : '0;

   // Round robin: rotate the request vector so rr_ptr lands on bit 0, take
   // the first set bit, then map the offset back to an absolute index.
   logic [NUM_REQ-1:0] rot_valid;
   logic [2:0]         pick_off, grant_pick, rr_next;
   logic [3:0]         pick_sum, next_sum;
   logic               found;

   assign rot_valid = NUM_REQ'({req_valid, req_valid} >> rr_ptr_q);

   always_comb begin
      found    = 1'b0;
      pick_off = 3'd0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && rot_valid[i]) begin
            found    = 1'b1;
            pick_off = 3'(i);
         end
      end
      pick_sum   = {1'b0, rr_ptr_q} + {1'b0, pick_off};
      grant_pick = (pick_sum >= 4'(NUM_REQ)) ? 3'(pick_sum - 4'(NUM_REQ)) : pick_sum[2:0];
      next_sum   = {1'b0, grant_pick} + 4'd1;
      rr_next    = (next_sum >= 4'(NUM_REQ)) ? 3'd0 : next_sum[2:0];
   end

   always_comb begin
      state_d       = state_q;
      tx_data_d     = tx_data_q;
      tx_start_d    = 1'b0;
      grant_valid_d = grant_valid_q;
      grant_id_d    = grant_id_q;
      busy_err_d    = busy_err_q;
      rr_ptr_d      = rr_ptr_q;
      beat_cnt_d    = beat_cnt_q;
      last_flag_d   = last_flag_q;
      is_tag_d      = is_tag_q;
      hi_cnt_d      = hi_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (|req_valid) begin
               grant_id_d    = grant_pick;
               grant_valid_d = 1'b1;
               rr_ptr_d      = rr_next;
               beat_cnt_d    = 8'd0;
               state_d       = TAG_EN ? S_TAG : S_LOAD;
            end
         end
         S_TAG: begin
            if (!tx_busy) begin
               tx_data_d  = TAG_BASE | {5'b00000, grant_id_q};
               tx_start_d = 1'b1;
               is_tag_d   = 1'b1;
               hi_cnt_d   = 2'd0;
               state_d    = S_WAIT_HI;
            end
         end
         S_LOAD: begin
            if (xfer) begin
               tx_data_d   = sel_data;
               tx_start_d  = 1'b1;
               is_tag_d    = 1'b0;
               beat_cnt_d  = beat_cnt_q + 8'd1;
               last_flag_d = sel_last || (beat_cnt_q == 8'(MAX_BURST - 1));
               hi_cnt_d    = 2'd0;
               state_d     = S_WAIT_HI;
            end else if (!sel_valid && (beat_cnt_q != 8'd0)) begin
               // Requester ran dry mid-burst: give the serializer back.
               grant_valid_d = 1'b0;
               state_d       = S_IDLE;
            end
         end
         S_WAIT_HI: begin
            if (tx_busy) begin
               state_d = S_WAIT_LO;
            end else if (hi_cnt_q == 2'd2) begin
               // Third idle cycle after the start: flag and move on anyway.
               busy_err_d = 1'b1;
               state_d    = S_WAIT_LO;
            end else begin
               hi_cnt_d = hi_cnt_q + 2'd1;
            end
         end
         S_WAIT_LO: begin
            if (!tx_busy) begin
               if (is_tag_q || !last_flag_q) begin
                  state_d = S_LOAD;
               end else begin
                  grant_valid_d = 1'b0;
                  state_d       = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         tx_data_q     <= 8'd0;
         tx_start_q    <= 1'b0;
         grant_valid_q <= 1'b0;
         grant_id_q    <= 3'd0;
         busy_err_q    <= 1'b0;
         rr_ptr_q      <= 3'd0;
         beat_cnt_q    <= 8'd0;
         last_flag_q   <= 1'b0;
         is_tag_q      <= 1'b0;
         hi_cnt_q      <= 2'd0;
      end else begin
         state_q       <= state_d;
         tx_data_q     <= tx_data_d;
         tx_start_q    <= tx_start_d;
         grant_valid_q <= grant_valid_d;
         grant_id_q    <= grant_id_d;
         busy_err_q    <= busy_err_d;
         rr_ptr_q      <= rr_ptr_d;
         beat_cnt_q    <= beat_cnt_d;
         last_flag_q   <= last_flag_d;
         is_tag_q      <= is_tag_d;
         hi_cnt_q      <= hi_cnt_d;
      end
   end

   assign tx_data     = tx_data_q;
   assign tx_start    = tx_start_q;
   assign grant_valid = grant_valid_q;
   assign grant_id    = grant_id_q;
   assign busy_err    = busy_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: per-requester byte queues, a uart_tx busy
// model, and a reference model that predicts the serialized byte stream and
// the requester owning each byte. A monitor compares every tx_start pulse
// against the predicted stream.
module tb_uart_tx_arbiter;

   localparam int         N    = 4;
   localparam bit         TAGE = 1'b1;
   localparam logic [7:0] TAGB = 8'hA0;
   localparam int         MAXB = 16;

   logic               clk;
   logic               rst_n;
   logic [N-1:0]       req_valid;
   logic [8*N-1:0]     req_data;
   logic [N-1:0]       req_last;
   logic [N-1:0]       req_ready;
   logic [7:0]         tx_data;
   logic               tx_start;
   logic               tx_busy;
   logic               grant_valid;
   logic [2:0]         grant_id;
   logic               busy_err;

   uart_tx_arbiter #(
      .NUM_REQ  (N),
      .TAG_EN   (TAGE),
      .TAG_BASE (TAGB),
      .MAX_BURST(MAXB)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_last   (req_last),
      .req_ready  (req_ready),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .tx_busy    (tx_busy),
      .grant_valid(grant_valid),
      .grant_id   (grant_id),
      .busy_err   (busy_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed { logic [7:0] d; logic l; } beat_t;
   typedef struct packed { logic [7:0] d; logic [2:0] g; } exp_t;

   beat_t   sq [N][$];
   exp_t    exp_q [$];
   int      m_ptr;
   logic [N-1:0] acc;
   int      n_tests;
   int      n_fail;
   bit      tie0;
   int      blen_max;
   int      blen_fixed;
   int      bcnt;
   logic    prev_start;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   task automatic push_beat(input int r, input logic [7:0] d, input logic l);
      beat_t b;
      b.d = d;
      b.l = l;
      sq[r].push_back(b);
   endtask

   // Reference model: round robin over non-empty requesters starting at
   // m_ptr; a burst runs until a byte flagged last, MAXB bytes, or the
   // requester's queue is exhausted.
   task automatic run_model();
      beat_t cq [N][$];
      exp_t  e;
      beat_t b;
      int    g;
      int    beats;
      bit    any;
      for (int i = 0; i < N; i++) cq[i] = sq[i];
      while (1) begin
         any = 1'b0;
         g   = 0;
         for (int k = 0; k < N; k++) begin
            if (!any && cq[(m_ptr + k) % N].size() > 0) begin
               any = 1'b1;
               g   = (m_ptr + k) % N;
            end
         end
         if (!any) break;
         m_ptr = (g + 1) % N;
         if (TAGE) begin
            e.d = TAGB | 8'(g);
            e.g = 3'(g);
            exp_q.push_back(e);
         end
         beats = 0;
         while (1) begin
            b = cq[g].pop_front();
            e.d = b.d;
            e.g = 3'(g);
            exp_q.push_back(e);
            beats++;
            if (b.l || beats == MAXB || cq[g].size() == 0) break;
         end
      end
   endtask

   // Requester side: retire bytes accepted at the previous posedge, then
   // present the head of each queue.
   initial begin
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      acc       = '0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < N; i++)
            if (acc[i] && sq[i].size() > 0) sq[i].delete(0);
         for (int i = 0; i < N; i++) begin
            if (sq[i].size() > 0) begin
               req_valid[i]       = 1'b1;
               req_data[8*i +: 8] = sq[i][0].d;
               req_last[i]        = sq[i][0].l;
            end else begin
               req_valid[i]       = 1'b0;
               req_data[8*i +: 8] = 8'h00;
               req_last[i]        = 1'b0;
            end
         end
         #1;
         acc = req_ready & req_valid;
      end
   end

   // uart_tx busy model.
   initial begin
      tx_busy = 1'b0;
      bcnt    = 0;
      forever begin
         @(negedge clk);
         if (tx_start === 1'b1) begin
            check("start_while_busy", 32'(tx_busy), 32'd0);
            if (!tie0) bcnt = (blen_fixed > 0) ? blen_fixed : int'($urandom_range(1, blen_max));
         end
         if (bcnt > 0) begin
            tx_busy = 1'b1;
            bcnt--;
         end else begin
            tx_busy = 1'b0;
         end
      end
   end

   // Scoreboard monitor.
   initial begin
      exp_t e;
      prev_start = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (tx_start === 1'b1) begin
            check("pulse_width", 32'(prev_start), 32'd0);
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_start: got data %0h with no byte expected", tx_data);
            end else begin
               e = exp_q.pop_front();
               check("tx_data", 32'(tx_data), 32'(e.d));
               check("grant_id_at_start", 32'(grant_id), 32'(e.g));
               check("grant_valid_at_start", 32'(grant_valid), 32'd1);
            end
         end
         prev_start = tx_start;
      end
   end

   task automatic wait_drain(input string nm);
      bit done;
      done = 1'b0;
      for (int c = 0; c < 3000 && !done; c++) begin
         @(negedge clk);
         #4;
         if (exp_q.size() == 0 && sq[0].size() == 0 && sq[1].size() == 0 &&
             sq[2].size() == 0 && sq[3].size() == 0 && grant_valid === 1'b0 && tx_busy === 1'b0)
            done = 1'b1;
      end
      check(nm, 32'(done), 32'd1);
   endtask

   task automatic load_start();
      @(negedge clk);
      #3;
   endtask

   task automatic wait_start(output bit seen);
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge clk);
         #2;
         if (tx_start === 1'b1) seen = 1'b1;
      end
   endtask

   initial begin
      bit seen;
      int n;
      n_tests    = 0;
      n_fail     = 0;
      tie0       = 1'b0;
      blen_max   = 4;
      blen_fixed = 0;
      m_ptr      = 0;
      rst_n      = 1'b0;

      repeat (3) @(negedge clk);
      #2;
      check("rst_tx_start", 32'(tx_start), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_grant_valid", 32'(grant_valid), 32'd0);
      check("rst_grant_id", 32'(grant_id), 32'd0);
      check("rst_busy_err", 32'(busy_err), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      rst_n = 1'b1;

      // All requesters, two single-byte bursts each: grants 0,1,2,3,0,1,2,3.
      load_start();
      for (int r = 0; r < N; r++) begin
         push_beat(r, 8'h30 + 8'(r), 1'b1);
         push_beat(r, 8'h40 + 8'(r), 1'b1);
      end
      run_model();
      wait_drain("drain_rr");

      // Single byte 55 from requester 0.
      load_start();
      push_beat(0, 8'h55, 1'b1);
      run_model();
      wait_drain("drain_single");
      check("gid_hold_0", 32'(grant_id), 32'd0);

      // Requester 2: 11, 22 (last) -> A2 11 22.
      load_start();
      push_beat(2, 8'h11, 1'b0);
      push_beat(2, 8'h22, 1'b1);
      run_model();
      wait_drain("drain_req2");
      check("gid_hold_2", 32'(grant_id), 32'd2);

      // Requester 1 streams 20 bytes without last: split at MAXB.
      load_start();
      for (int j = 0; j < 20; j++) push_beat(1, 8'(j + 1), 1'b0);
      run_model();
      wait_drain("drain_maxburst");

      // Randomized phases.
      for (int p = 0; p < 12; p++) begin
         blen_max = int'($urandom_range(1, 5));
         load_start();
         for (int r = 0; r < N; r++) begin
            n = int'($urandom_range(0, 6));
            if ($urandom_range(0, 5) == 0) n = int'($urandom_range(14, 22));
            for (int j = 0; j < n; j++)
               push_beat(r, 8'($urandom), ($urandom_range(0, 2) == 0));
         end
         run_model();
         wait_drain("drain_random");
      end

      // uart_tx never raises busy: busy_err appears 3 cycles after the pulse.
      tie0 = 1'b1;
      load_start();
      push_beat(3, 8'h5A, 1'b1);
      run_model();
      wait_start(seen);
      check("busy_err_start_seen", 32'(seen), 32'd1);
      check("busy_err_at_pulse", 32'(busy_err), 32'd0);
      repeat (2) @(negedge clk);
      #2;
      check("busy_err_plus2", 32'(busy_err), 32'd0);
      @(negedge clk);
      #2;
      check("busy_err_plus3", 32'(busy_err), 32'd1);
      wait_drain("drain_busy_err");
      check("busy_err_sticky", 32'(busy_err), 32'd1);
      tie0 = 1'b0;

      load_start();
      push_beat(1, 8'hC3, 1'b1);
      run_model();
      wait_drain("drain_after_err");
      check("busy_err_sticky2", 32'(busy_err), 32'd1);

      // Reset while in WAIT_LO, then arbitration restarts at requester 0.
      blen_fixed = 6;
      load_start();
      push_beat(2, 8'h71, 1'b0);
      push_beat(2, 8'h72, 1'b0);
      push_beat(2, 8'h73, 1'b1);
      run_model();
      wait_start(seen);
      check("rst_mid_start_seen", 32'(seen), 32'd1);
      @(negedge clk);
      #3;
      rst_n = 1'b0;
      for (int r = 0; r < N; r++) sq[r].delete();
      exp_q.delete();
      acc   = '0;
      m_ptr = 0;
      @(negedge clk);
      #2;
      check("rstmid_tx_start", 32'(tx_start), 32'd0);
      check("rstmid_grant_valid", 32'(grant_valid), 32'd0);
      check("rstmid_req_ready", 32'(req_ready), 32'd0);
      check("rstmid_busy_err", 32'(busy_err), 32'd0);
      check("rstmid_grant_id", 32'(grant_id), 32'd0);
      #1;
      rst_n = 1'b1;
      wait_drain("drain_rst_idle");
      blen_fixed = 0;

      load_start();
      for (int r = 0; r < N; r++) push_beat(r, 8'h90 + 8'(r), 1'b1);
      run_model();
      wait_drain("drain_after_rst");

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer among NUM_REQ byte-stream requesters using round-robin arbitration with burst locking.
- Sequences the serializer's start/busy handshake. Optionally prefixes each burst with a tag byte that identifies the requester.
- Sits between the per-channel FIFO read sides and the uart_tx instance, in the same clock domain as uart_tx.

Parameters:
- NUM_REQ, 4, number of requesters, 2..8.
- TAG_EN, 1, 1 = send tag byte (TAG_BASE | grant_id) before each burst; 0 = payload only.
- TAG_BASE, 8'hA0, tag byte base; low 3 bits must be 0.
- MAX_BURST, 16, maximum payload bytes per grant, 1..255.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  requester i has a byte.
- req_data  in  8*NUM_REQ  byte of requester i at [8i+7:8i].
- req_last  in  NUM_REQ  byte of requester i ends its burst.
- req_ready  out  NUM_REQ  one-hot accept strobe, combinational.
- tx_data  out  8  byte to uart_tx data_in, registered.
- tx_start  out  1  one-cycle start pulse to uart_tx, registered.
- tx_busy  in  1  uart_tx busy.
- grant_valid  out  1  a burst is in progress.
- grant_id  out  3  current or last granted requester.
- busy_err  out  1  sticky: uart_tx failed to raise busy after a start pulse.

Behaviour:
- Reset: rst_n sampled low at posedge clk. The following are all 0: state=IDLE, tx_start, tx_data, grant_valid, grant_id, busy_err, rr_ptr, beat_cnt, last_flag, is_tag. req_ready=0.
- Reset mid-operation: any accepted but unsent byte is dropped, and tx_start is low on the next cycle.
- States: IDLE, TAG, LOAD, WAIT_HI, WAIT_LO.
- IDLE:
  - If any req_valid is high, grant the first asserted index scanning upward from rr_ptr, wrapping modulo NUM_REQ.
  - Register grant_id, set grant_valid=1, set rr_ptr<=(grant+1) mod NUM_REQ, set beat_cnt<=0.
  - Go to TAG if TAG_EN, else LOAD. Otherwise stay in IDLE.
- TAG:
  - If tx_busy==0: tx_data<=TAG_BASE|grant_id, tx_start<=1, is_tag<=1, go to WAIT_HI.
  - Otherwise hold in TAG.
- LOAD:
  - req_ready[grant_id]=req_valid[grant_id] & ~tx_busy. All other req_ready bits are 0. req_ready is 0 in every other state.
  - On transfer: tx_data<=req_data[grant_id], tx_start<=1, is_tag<=0, beat_cnt<=beat_cnt+1, last_flag<=req_last[grant_id] | (beat_cnt==MAX_BURST-1). Go to WAIT_HI.
  - If req_valid[grant_id]==0 and beat_cnt>0: release the burst (gap end), grant_valid<=0, go to IDLE.
  - If req_valid[grant_id]==0 and beat_cnt==0: hold in LOAD.
- WAIT_HI:
  - tx_start is 0 in this state (exactly one-cycle pulse).
  - On tx_busy==1: go to WAIT_LO.
  - If 3 cycles elapse in WAIT_HI without tx_busy: busy_err<=1, go to WAIT_LO anyway.
- WAIT_LO: on tx_busy==0:
  - is_tag: go to LOAD.
  - last_flag: grant_valid<=0, go to IDLE.
  - Otherwise: go to LOAD.
- Latency with TAG_EN=0 and the UART idle: req_valid rising in IDLE → req_ready high 1 cycle later → tx_start high the cycle after that. Back-to-back bytes are issued 1 cycle after tx_busy falls.
- Fairness: the just-served requester drops to lowest priority. A burst is never preempted.
- Simultaneous requests all resolve in IDLE; no requester is starved beyond NUM_REQ-1 bursts.
- grant_id holds its last value while grant_valid=0.
- Width: beat_cnt is 8 bits. grant_id is zero-extended when NUM_REQ≤4.

Test Plan:
- TAG_EN=0, req 0 sends the single byte 8'h55 with last=1 → one tx_start pulse with tx_data=55. grant_valid falls after busy falls. The uart_tx line shows the 55 frame.
- TAG_EN=1, req 2 sends bytes 11, 22 (last on 22) → serialized sequence A2, 11, 22. Exactly 3 tx_start pulses, each only when tx_busy==0.
- All 4 requesters hold valid with single-byte bursts, each repeated twice → grant order 0,1,2,3,0,1,2,3.
- Req 1 streams 20 bytes with no last, MAX_BURST=16 → grant released after 16 bytes, then re-granted to req 1 only if no other requester is valid.
- Tie tx_busy to 0 and send one byte → busy_err=1 exactly 3 cycles after the pulse. The FSM returns to IDLE, and busy_err stays 1 until reset.
- Assert rst_n=0 for one cycle while in WAIT_LO → next cycle: state IDLE, tx_start=0, grant_valid=0, req_ready=0, busy_err=0, and the arbitration order restarts at req 0.
